router_ctrl_fsm: RTL and testbench

Sequencing controller for the 1x3 router input path. It decodes the header address, waits for the destination FIFO to drain, and steps the register block through header, payload, full-stall, parity and parity-check phases. It drives the phase strobes consumed by the register block and the write enable consumed by the synchronizer/FIFO side. It sits between the source interface, the three output FIFOs' status flags and the register datapath.

---
 rtl/router_pkg.sv | 31 +++
 rtl/router_ctrl_fsm_if.sv | 54 +++++
 rtl/router_fsm_stats.sv | 55 +++++
 rtl/router_ctrl_fsm.sv | 88 ++++++++
 tb/tb_router_ctrl_fsm.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared types and constants for the router input-path controller.
package router_pkg;

    typedef enum logic [2:0] {
        StDecodeAddr,
        StLoadFirstData,
        StLoadData,
        StFifoFull,
        StLoadAfterFull,
        StLoadParity,
        StCheckParity,
        StWaitTillEmpty
    } router_state_t;

    localparam logic [1:0] ADDR_INVALID = 2'd3;
    localparam int unsigned STAT_W = 16;

    // Pick one of three per-FIFO flags; the invalid address selects nothing.
    function automatic logic sel3(input logic [2:0] v, input logic [1:0] idx);
        logic r;
        r = 1'b0;
        case (idx)
            2'd0:    r = v[0];
            2'd1:    r = v[1];
            2'd2:    r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Bundle of source, FIFO-status and register-block signals around the router controller.
// Optional stats outputs appear when ROUTER_FSM_STATS_EN is defined.
interface router_ctrl_fsm_if;
    import router_pkg::*;

    logic       pkt_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0;
    logic       fifo_empty_1;
    logic       fifo_empty_2;
    logic       soft_reset_0;
    logic       soft_reset_1;
    logic       soft_reset_2;
    logic       parity_done;
    logic       low_pkt_valid;

    logic       detect_addr;
    logic       lfd_state;
    logic       ld_state;
    logic       laf_state;
    logic       full_state;
    logic       write_enb_reg;
    logic       rst_int_reg;
    logic       busy;
`ifdef ROUTER_FSM_STATS_EN
    logic [STAT_W-1:0] pkt_cnt;
    logic [STAT_W-1:0] drop_cnt;
    logic [STAT_W-1:0] abort_cnt;
`endif

    // Environment side: drives status inputs, observes phase strobes.
    modport master (
        output pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
        input  detect_addr, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
               rst_int_reg, busy
`ifdef ROUTER_FSM_STATS_EN
        , input pkt_cnt, drop_cnt, abort_cnt
`endif
    );

    // Controller side.
    modport slave (
        input  pkt_valid, data_in, fifo_full, fifo_empty_0, fifo_empty_1, fifo_empty_2,
               soft_reset_0, soft_reset_1, soft_reset_2, parity_done, low_pkt_valid,
        output detect_addr, lfd_state, ld_state, laf_state, full_state, write_enb_reg,
               rst_int_reg, busy
`ifdef ROUTER_FSM_STATS_EN
        , output pkt_cnt, drop_cnt, abort_cnt
`endif
    );

endinterface

// File: rtl/router_fsm_stats.sv
// Saturating packet/drop/abort counters for the router controller (ROUTER_FSM_STATS_EN).
module router_fsm_stats
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              cpe_i,
    input  logic              in_da_i,
    input  logic              pkt_valid_i,
    input  logic [1:0]        data_in_i,
    input  logic              abort_i,
    output logic [STAT_W-1:0] pkt_cnt_o,
    output logic [STAT_W-1:0] drop_cnt_o,
    output logic [STAT_W-1:0] abort_cnt_o
);

    localparam logic [STAT_W-1:0] One = {{(STAT_W-1){1'b0}}, 1'b1};

    logic              pv_q, pv_d;
    logic [STAT_W-1:0] pkt_q, pkt_d;
    logic [STAT_W-1:0] drop_q, drop_d;
    logic [STAT_W-1:0] abort_q, abort_d;
    logic              drop_evt;

    always_comb begin
        pv_d     = pkt_valid_i;
        drop_evt = in_da_i && pkt_valid_i && !pv_q && (data_in_i == ADDR_INVALID);
        pkt_d    = pkt_q;
        drop_d   = drop_q;
        abort_d  = abort_q;
        // Counters stick at all-ones rather than wrapping.
        if (cpe_i && (pkt_q != '1))      pkt_d   = pkt_q + One;
        if (drop_evt && (drop_q != '1))  drop_d  = drop_q + One;
        if (abort_i && (abort_q != '1))  abort_d = abort_q + One;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pv_q    <= 1'b0;
            pkt_q   <= '0;
            drop_q  <= '0;
            abort_q <= '0;
        end else begin
            pv_q    <= pv_d;
            pkt_q   <= pkt_d;
            drop_q  <= drop_d;
            abort_q <= abort_d;
        end
    end

    assign pkt_cnt_o   = pkt_q;
    assign drop_cnt_o  = drop_q;
    assign abort_cnt_o = abort_q;

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router 1x3 input-path sequencer: address decode, drain wait, load/full/parity phases.
// Define ROUTER_FSM_STATS_EN to add the pkt/drop/abort counters.
module router_ctrl_fsm
    import router_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    router_ctrl_fsm_if.slave  bus
);

    router_state_t state_q, state_d;
    logic [1:0]    addr_q, addr_d;
    logic [2:0]    fifo_empty;
    logic [2:0]    soft_reset;
    logic          soft_abort;

    always_comb begin
        fifo_empty = {bus.fifo_empty_2, bus.fifo_empty_1, bus.fifo_empty_0};
        soft_reset = {bus.soft_reset_2, bus.soft_reset_1, bus.soft_reset_0};
        soft_abort = (state_q != StDecodeAddr) && sel3(soft_reset, addr_q);

        addr_d = addr_q;
        if ((state_q == StDecodeAddr) && bus.pkt_valid) addr_d = bus.data_in;

        state_d = state_q;
        unique case (state_q)
            StDecodeAddr: begin
                if (bus.pkt_valid && (bus.data_in != ADDR_INVALID)) begin
                    state_d = sel3(fifo_empty, bus.data_in) ? StLoadFirstData : StWaitTillEmpty;
                end
            end
            StWaitTillEmpty: if (sel3(fifo_empty, addr_q)) state_d = StLoadFirstData;
            StLoadFirstData: state_d = StLoadData;
            StLoadData: begin
                if (bus.fifo_full)       state_d = StFifoFull;
                else if (!bus.pkt_valid) state_d = StLoadParity;
            end
            StFifoFull: if (!bus.fifo_full) state_d = StLoadAfterFull;
            StLoadAfterFull: begin
                if (bus.parity_done)        state_d = StDecodeAddr;
                else if (bus.low_pkt_valid) state_d = StLoadParity;
                else                        state_d = StLoadData;
            end
            StLoadParity:  state_d = StCheckParity;
            StCheckParity: state_d = bus.fifo_full ? StFifoFull : StDecodeAddr;
            default:       state_d = StDecodeAddr;
        endcase

        // A read-timeout on our own FIFO abandons the packet.
        if (soft_abort) state_d = StDecodeAddr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= StDecodeAddr;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    assign bus.detect_addr   = (state_q == StDecodeAddr);
    assign bus.lfd_state     = (state_q == StLoadFirstData);
    assign bus.ld_state      = (state_q == StLoadData);
    assign bus.laf_state     = (state_q == StLoadAfterFull);
    assign bus.full_state    = (state_q == StFifoFull);
    assign bus.write_enb_reg = (state_q == StLoadData) || (state_q == StLoadParity) ||
                               (state_q == StLoadAfterFull);
    assign bus.rst_int_reg   = (state_q == StCheckParity);
    assign bus.busy          = !((state_q == StDecodeAddr) || (state_q == StLoadData));

`ifdef ROUTER_FSM_STATS_EN
    router_fsm_stats u_stats (
        .clk         (clk),
        .rst         (rst),
        .cpe_i       (state_q == StCheckParity),
        .in_da_i     (state_q == StDecodeAddr),
        .pkt_valid_i (bus.pkt_valid),
        .data_in_i   (bus.data_in),
        .abort_i     (soft_abort),
        .pkt_cnt_o   (bus.pkt_cnt),
        .drop_cnt_o  (bus.drop_cnt),
        .abort_cnt_o (bus.abort_cnt)
    );
`endif

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Scoreboard bench for router_ctrl_fsm: directed cycles push expected phases, a monitor compares.
module tb_router_ctrl_fsm;

    typedef enum int {ExDa, ExLfd, ExLd, ExFfs, ExLaf, ExLp, ExCpe, ExWte} exp_st_e;

    typedef struct {
        exp_st_e     st;
        int          idx;
        logic [15:0] pkt;
        logic [15:0] drop;
        logic [15:0] abort;
    } exp_t;

    logic clk;
    logic rst;
    router_ctrl_fsm_if bus();

    router_ctrl_fsm dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          step = 0;
    logic [15:0] e_pkt = 0;
    logic [15:0] e_drop = 0;
    logic [15:0] e_abort = 0;

    // {detect_addr, lfd, ld, laf, full, write_enb, rst_int, busy}
    function automatic logic [7:0] outs_of(input exp_st_e s);
        logic [7:0] v;
        case (s)
            ExDa:    v = 8'b1000_0000;
            ExLfd:   v = 8'b0100_0001;
            ExLd:    v = 8'b0010_0100;
            ExLaf:   v = 8'b0001_0101;
            ExFfs:   v = 8'b0000_1001;
            ExLp:    v = 8'b0000_0101;
            ExCpe:   v = 8'b0000_0011;
            default: v = 8'b0000_0001;
        endcase
        return v;
    endfunction

    // Queue the state expected after the coming rising edge, then move to the next falling edge.
    task automatic tick(input exp_st_e s);
        exp_t e;
        e.st = s; e.idx = step; e.pkt = e_pkt; e.drop = e_drop; e.abort = e_abort;
        sb_q.push_back(e);
        step++;
        @(negedge clk);
    endtask

    initial begin
        exp_t       e;
        logic [7:0] act;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                act = {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.laf_state,
                       bus.full_state, bus.write_enb_reg, bus.rst_int_reg, bus.busy};
                total++;
                if (act !== outs_of(e.st)) begin
                    bad++;
                    $display("FAIL strobes step %0d (%s): got %b want %b", e.idx, e.st.name(),
                             act, outs_of(e.st));
                end
`ifdef ROUTER_FSM_STATS_EN
                total++;
                if ({bus.pkt_cnt, bus.drop_cnt, bus.abort_cnt} !== {e.pkt, e.drop, e.abort}) begin
                    bad++;
                    $display("FAIL stats step %0d: got pkt=%0d drop=%0d abort=%0d want %0d/%0d/%0d",
                             e.idx, bus.pkt_cnt, bus.drop_cnt, bus.abort_cnt,
                             e.pkt, e.drop, e.abort);
                end
`endif
            end
        end
    end

    initial begin
        bus.pkt_valid = 0; bus.data_in = 0; bus.fifo_full = 0;
        bus.fifo_empty_0 = 1; bus.fifo_empty_1 = 1; bus.fifo_empty_2 = 1;
        bus.soft_reset_0 = 0; bus.soft_reset_1 = 0; bus.soft_reset_2 = 0;
        bus.parity_done = 0; bus.low_pkt_valid = 0;

        // Reset held for two edges
        rst = 0;
        tick(ExDa); tick(ExDa);
        rst = 1;

        // Clean packet to FIFO 1: header + 3 payload bytes, then parity
        bus.pkt_valid = 1; bus.data_in = 2'd1;
        tick(ExLfd);
        bus.data_in = 2'd2;
        tick(ExLd); tick(ExLd); tick(ExLd);
        bus.pkt_valid = 0;
        tick(ExLp); tick(ExCpe);
        e_pkt = 1;
        tick(ExDa);

        // FIFO 2 busy for 5 cycles
        bus.pkt_valid = 1; bus.data_in = 2'd2; bus.fifo_empty_2 = 0;
        for (int i = 0; i < 5; i++) tick(ExWte);
        bus.fifo_empty_2 = 1;
        tick(ExLfd); tick(ExLd);
        bus.pkt_valid = 0;
        tick(ExLp); tick(ExCpe);
        e_pkt = 2;
        tick(ExDa);

        // Full stall in the second LD cycle, then LAF falls back to LD
        bus.pkt_valid = 1; bus.data_in = 2'd0;
        tick(ExLfd); tick(ExLd); tick(ExLd);
        bus.fifo_full = 1;
        tick(ExFfs); tick(ExFfs); tick(ExFfs);
        bus.fifo_full = 0;
        tick(ExLaf); tick(ExLd);
        bus.pkt_valid = 0;
        tick(ExLp); tick(ExCpe);
        e_pkt = 3;
        tick(ExDa);

        // LAF via low_pkt_valid to LP, CPE with full to FFS, LAF with parity_done to DA
        bus.pkt_valid = 1; bus.data_in = 2'd0;
        tick(ExLfd); tick(ExLd);
        bus.fifo_full = 1;
        tick(ExFfs);
        bus.fifo_full = 0; bus.low_pkt_valid = 1;
        tick(ExLaf); tick(ExLp);
        bus.low_pkt_valid = 0; bus.fifo_full = 1;
        tick(ExCpe);
        e_pkt = 4;
        tick(ExFfs);
        bus.fifo_full = 0;
        tick(ExLaf);
        bus.parity_done = 1;
        tick(ExDa);
        bus.parity_done = 0; bus.pkt_valid = 0;
        tick(ExDa);

        // Soft reset: other FIFO ignored, own FIFO aborts; no effect while in DA
        bus.pkt_valid = 1; bus.data_in = 2'd0;
        tick(ExLfd); tick(ExLd);
        bus.soft_reset_1 = 1;
        tick(ExLd);
        bus.soft_reset_1 = 0; bus.soft_reset_0 = 1;
        e_abort = 1;
        tick(ExDa);
        bus.pkt_valid = 0;
        tick(ExDa);
        bus.soft_reset_0 = 0;

        // Invalid address held for 4 cycles is dropped once
        bus.pkt_valid = 1; bus.data_in = 2'd3;
        e_drop = 1;
        tick(ExDa); tick(ExDa); tick(ExDa); tick(ExDa);
        bus.pkt_valid = 0;
        tick(ExDa);

        // Let the monitor drain the scoreboard, bounded
        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
        if (sb_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
